c2h_pkt_framer: RTL
===================

C2H_PKT_FRAMER -- requirements
Module: c2h_pkt_framer

Interface
REQ-001 The block SHALL have parameter DATA_W, default `XDMA_AXI_DATA_WIDTH (256), setting the AXI-stream data width.
REQ-002 The block SHALL have parameter MAGIC, default 32'hDB5A_C0DE, setting the trailer signature.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 trailer_on  input  1  append a trailer beat to each packet; sampled only at packet start.
REQ-006 s_tdata  input  DATA_W  upstream data from readback_engine c2h_tdata_0.
REQ-007 s_tvalid, s_tlast  input  1 each  upstream valid and end-of-packet.
REQ-008 s_tkeep  input  DATA_W/8  upstream byte enables; forwarded unchanged.
REQ-009 s_tready  output  1  upstream ready.
REQ-010 m_tdata  output  DATA_W  data to XDMA C2H channel 0.
REQ-011 m_tkeep  output  DATA_W/8  byte enables to XDMA.
REQ-012 m_tvalid, m_tlast  output  1 each  valid and end-of-packet to XDMA.
REQ-013 m_tready  input  1  XDMA ready.
REQ-014 pkt_seq  output  32  number of packets completed since reset.

Function
REQ-015 The block SHALL have two states: PASS and TRAILER.
REQ-016 The block SHALL hold the output in a single register stage.
- s_tready = (state==PASS) && (~m_tvalid || m_tready).
- Input-to-output latency SHALL be 1 cycle.
- Throughput SHALL be 1 beat/cycle while m_tready is high.
REQ-017 A beat SHALL be accepted when s_tvalid && s_tready, and SHALL be emitted when m_tvalid && m_tready.
REQ-018 Output SHALL hold stable while m_tvalid && ~m_tready (AXI-stream rule).
REQ-019 A packet SHALL start at the first accepted beat after reset or after its previous packet completed; trailer_on SHALL be latched into trl_en_r on that beat.
REQ-020 With trl_en_r=0:
- beats SHALL pass unchanged, including tlast;
- pkt_seq SHALL increment when an s_tlast beat is accepted;
- the state SHALL remain PASS.
REQ-021 With trl_en_r=1:
- data beats SHALL be forwarded with m_tlast forced low;
- acceptance of the s_tlast beat SHALL move the state to TRAILER.
REQ-022 In TRAILER:
- s_tready SHALL be 0;
- once the last data beat leaves the register (or the register is empty), the trailer beat SHALL load with m_tlast=1 and m_tkeep all ones;
- on trailer handshake, the state SHALL return to PASS and pkt_seq SHALL increment.
REQ-023 Trailer layout SHALL be:
- [31:0] = MAGIC;
- [63:32] = pkt_seq before the increment;
- [79:64] = beat count of the packet's data beats;
- [DATA_W-1:80] = checksum field (see REQ-031).
REQ-024 The beat counter SHALL be 16-bit, SHALL count accepted data beats including the s_tlast beat, SHALL saturate at 16'hFFFF, and SHALL clear on packet completion.
REQ-025 pkt_seq SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-026 A single-beat packet (s_tlast on the first beat) with trl_en_r=1 SHALL produce a count of 1 and exactly 2 output beats.
REQ-027 Changes to trailer_on mid-packet SHALL be ignored.

Reset
REQ-028 When rst is asserted, on that clock edge:
- m_tvalid = 0, m_tlast = 0, m_tdata = 0;
- pkt_seq = 0, beat count = 0, checksum = 0;
- state = PASS, trl_en_r = 0.
REQ-029 Reset asserted mid-packet SHALL discard buffered beats and any pending trailer; no partial trailer SHALL be emitted afterward.
REQ-030 s_tready SHALL be 0 while rst is high.

Configuration
REQ-031 Macro C2H_PKT_CHECKSUM_EN:
- Defined: a running XOR of all accepted data-beat s_tdata[DATA_W-1:80] SHALL be kept, placed in trailer [DATA_W-1:80], and cleared at packet completion.
- Undefined: trailer [DATA_W-1:80] SHALL be 0 and no checksum register SHALL be built.

Verification
REQ-032 Trailer on, 4 beats 0x1..0x4, m_tready=1: outputs SHALL be 5 beats, with tlast only on beat 5; trailer [31:0]=0xDB5AC0DE, [63:32]=0, [79:64]=4; pkt_seq becomes 1.
REQ-033 Trailer off, 3-beat packet: outputs SHALL be the same 3 beats, tlast on beat 3, 1-cycle latency; pkt_seq increments to 1.
REQ-034 m_tready toggles 1,0,0,1 during a 2-beat packet: m_tdata SHALL stay stable while stalled; no beat SHALL be lost or duplicated; trailer count = 2.
REQ-035 trailer_on goes 1->0 on the 2nd beat of a 3-beat packet: a trailer SHALL still be emitted with count=3; the next packet SHALL have no trailer.
REQ-036 rst asserted while in TRAILER before the trailer handshake: next cycle m_tvalid=0 and pkt_seq=0; the next packet's trailer SHALL have seq=0.
REQ-037 With C2H_PKT_CHECKSUM_EN defined, beats with bits [DATA_W-1:80] = A and then B: trailer [DATA_W-1:80] SHALL equal A^B; with the macro undefined, it SHALL be 0.

Source files
------------

// File: rtl/c2h_pkt_framer.sv
// c2h_pkt_framer: AXI-stream C2H framer, one register stage, optional trailer.
// Build macro C2H_PKT_CHECKSUM_EN adds a running XOR checksum to the trailer.
`ifndef XDMA_AXI_DATA_WIDTH
`define XDMA_AXI_DATA_WIDTH 256
`endif

module c2h_pkt_framer #(
   parameter int          DATA_W = `XDMA_AXI_DATA_WIDTH,
   parameter logic [31:0] MAGIC  = 32'hDB5A_C0DE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                trailer_on,
   input  logic [DATA_W-1:0]   s_tdata,
   input  logic                s_tvalid,
   input  logic                s_tlast,
   input  logic [DATA_W/8-1:0] s_tkeep,
   output logic                s_tready,
   output logic [DATA_W-1:0]   m_tdata,
   output logic [DATA_W/8-1:0] m_tkeep,
   output logic                m_tvalid,
   output logic                m_tlast,
   input  logic                m_tready,
   output logic [31:0]         pkt_seq
);

   localparam int KEEP_W = DATA_W / 8;
   localparam int CS_W   = DATA_W - 80;

   typedef enum logic {PASS, TRAILER} state_t;

   state_t              state_q, state_d;
   logic                trl_en_r, trl_en_d;
   logic                in_pkt_q, in_pkt_d;
   logic                vld_q, vld_d;
   logic                last_q, last_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [KEEP_W-1:0]   keep_q, keep_d;
   logic [15:0]         cnt_q, cnt_d;
   logic [31:0]         seq_q, seq_d;

   logic                acc;
   logic                emit;
   logic                start;
   logic                cur_trl;
   logic                trl_held;
   logic [15:0]         cnt_inc;
   logic [CS_W-1:0]     csum_fld;
   logic [DATA_W-1:0]   trl_beat;

`ifdef C2H_PKT_CHECKSUM_EN
   logic [CS_W-1:0]     csum_q, csum_d;
   assign csum_fld = csum_q;
`else
   assign csum_fld = '0;
`endif

   assign s_tready = !rst && (state_q == PASS) && (!vld_q || m_tready);
   assign acc      = s_tvalid && s_tready;
   assign emit     = vld_q && m_tready;
   assign start    = acc && !in_pkt_q;
   // trailer_on only matters on the first beat; later beats use the latch
   assign cur_trl  = start ? trailer_on : trl_en_r;
   // data beats of a trailered packet never carry tlast, so a valid
   // tlast in TRAILER means the trailer itself is in the register
   assign trl_held = vld_q && last_q;
   assign cnt_inc  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
   assign trl_beat = {csum_fld, cnt_q, seq_q, MAGIC};

   assign m_tdata  = data_q;
   assign m_tkeep  = keep_q;
   assign m_tvalid = vld_q;
   assign m_tlast  = last_q;
   assign pkt_seq  = seq_q;

   // next-state: accept/forward data in PASS, load and drain trailer in TRAILER
   always_comb begin
      state_d  = state_q;
      trl_en_d = trl_en_r;
      in_pkt_d = in_pkt_q;
      vld_d    = vld_q;
      last_d   = last_q;
      data_d   = data_q;
      keep_d   = keep_q;
      cnt_d    = cnt_q;
      seq_d    = seq_q;
`ifdef C2H_PKT_CHECKSUM_EN
      csum_d   = csum_q;
`endif
      unique case (state_q)
         PASS: begin
            if (emit) begin
               vld_d = 1'b0;
            end
            if (acc) begin
               vld_d    = 1'b1;
               data_d   = s_tdata;
               keep_d   = s_tkeep;
               last_d   = s_tlast && !cur_trl;
               trl_en_d = cur_trl;
               in_pkt_d = !s_tlast;
               if (s_tlast && !cur_trl) begin
                  seq_d  = seq_q + 32'd1;
                  cnt_d  = '0;
`ifdef C2H_PKT_CHECKSUM_EN
                  csum_d = '0;
`endif
               end else begin
                  cnt_d  = cnt_inc;
`ifdef C2H_PKT_CHECKSUM_EN
                  csum_d = csum_q ^ s_tdata[DATA_W-1:80];
`endif
                  if (s_tlast) begin
                     state_d = TRAILER;
                  end
               end
            end
         end
         TRAILER: begin
            if (trl_held) begin
               if (m_tready) begin
                  vld_d   = 1'b0;
                  last_d  = 1'b0;
                  state_d = PASS;
                  seq_d   = seq_q + 32'd1;
                  cnt_d   = '0;
`ifdef C2H_PKT_CHECKSUM_EN
                  csum_d  = '0;
`endif
               end
            end else if (!vld_q || m_tready) begin
               vld_d  = 1'b1;
               last_d = 1'b1;
               keep_d = '1;
               data_d = trl_beat;
            end
         end
      endcase
   end

   // state and output register, synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= PASS;
         trl_en_r <= 1'b0;
         in_pkt_q <= 1'b0;
         vld_q    <= 1'b0;
         last_q   <= 1'b0;
         data_q   <= '0;
         keep_q   <= '0;
         cnt_q    <= '0;
         seq_q    <= '0;
`ifdef C2H_PKT_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         trl_en_r <= trl_en_d;
         in_pkt_q <= in_pkt_d;
         vld_q    <= vld_d;
         last_q   <= last_d;
         data_q   <= data_d;
         keep_q   <= keep_d;
         cnt_q    <= cnt_d;
         seq_q    <= seq_d;
`ifdef C2H_PKT_CHECKSUM_EN
         csum_q   <= csum_d;
`endif
      end
   end

endmodule
